// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM for a small MIPS subset with a per-access memory wait timeout.
// Defining MULTICYCLE_CTRL_RETIRE_CNT_EN adds a 16-bit retired-instruction counter output.
module multicycle_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [5:0]  opcode,
   input  logic        zero,
   input  logic        mem_ready,
   output logic        pc_wr,
   output logic        ir_wr,
   output logic        mem_rd,
   output logic        mem_wr,
   output logic        reg_wr,
   output logic        reg_dst,
   output logic        mem_to_reg,
   output logic        alu_src,
   output logic        pc_src,
   output logic        ext_op,
   output logic [1:0]  alu_op,
   output logic [2:0]  state,
   output logic        illegal
`ifdef MULTICYCLE_CTRL_RETIRE_CNT_EN
   ,
   output logic [15:0] retire_cnt
`endif
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_ERROR  = 3'd7
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;

   localparam logic [7:0] WAIT_LIMIT = 8'(MEM_TIMEOUT);

   state_t     state_q;
   state_t     state_d;
   logic [5:0] op_q;
   logic [7:0] wait_cnt;
   logic       illegal_q;
   logic       opcode_legal;
   logic       wait_expired;

   logic pc_wr_c;
   logic ir_wr_c;
   logic mem_wr_c;
   logic reg_wr_c;

   always_comb begin
      opcode_legal = 1'b0;
      case (opcode)
         OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE: opcode_legal = 1'b1;
         default: opcode_legal = 1'b0;
      endcase
   end

   assign wait_expired = (wait_cnt == WAIT_LIMIT);

   // Next-state logic; a ready memory always wins over an expiring wait counter.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH: begin
            if (mem_ready)
               state_d = S_DECODE;
            else if (wait_expired)
               state_d = S_ERROR;
         end
         S_DECODE: state_d = opcode_legal ? S_EXEC : S_ERROR;
         S_EXEC: begin
            case (op_q)
               OP_RTYPE, OP_ADDI: state_d = S_WB;
               OP_LW, OP_SW:      state_d = S_MEM;
               OP_BEQ, OP_BNE:    state_d = S_FETCH;
               default:           state_d = S_ERROR;
            endcase
         end
         S_MEM: begin
            if (mem_ready) begin
               if (op_q == OP_LW)
                  state_d = S_WB;
               else if (op_q == OP_SW)
                  state_d = S_FETCH;
               else
                  state_d = S_ERROR;
            end else if (wait_expired) begin
               state_d = S_ERROR;
            end
         end
         S_WB:    state_d = S_FETCH;
         default: state_d = S_ERROR;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_FETCH;
         op_q      <= 6'd0;
         wait_cnt  <= 8'd0;
         illegal_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == S_DECODE) begin
            op_q <= opcode;
            if (!opcode_legal)
               illegal_q <= 1'b1;
         end
         // Any state change restarts the count, which covers every entry into FETCH or MEM.
         if (state_d != state_q)
            wait_cnt <= 8'd0;
         else if ((state_q == S_FETCH || state_q == S_MEM) && !mem_ready)
            wait_cnt <= wait_cnt + 8'd1;
      end
   end

`ifdef MULTICYCLE_CTRL_RETIRE_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         retire_cnt <= 16'd0;
      else if (state_d == S_FETCH &&
               (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB))
         retire_cnt <= retire_cnt + 16'd1;
   end
`endif

   always_comb begin
      pc_wr_c    = 1'b0;
      ir_wr_c    = 1'b0;
      mem_rd     = 1'b0;
      mem_wr_c   = 1'b0;
      reg_wr_c   = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      alu_src    = 1'b0;
      pc_src     = 1'b0;
      ext_op     = 1'b0;
      alu_op     = 2'b00;
      case (state_q)
         S_FETCH: begin
            mem_rd = 1'b1;
            if (mem_ready) begin
               ir_wr_c = 1'b1;
               pc_wr_c = 1'b1;
            end
         end
         S_EXEC: begin
            case (op_q)
               OP_RTYPE: alu_op = 2'b10;
               OP_ADDI, OP_LW, OP_SW: begin
                  alu_src = 1'b1;
                  ext_op  = 1'b1;
               end
               OP_BEQ, OP_BNE: begin
                  alu_op  = 2'b01;
                  ext_op  = 1'b1;
                  pc_src  = 1'b1;
                  pc_wr_c = (op_q == OP_BEQ) ? zero : !zero;
               end
               default: ;
            endcase
         end
         S_MEM: begin
            if (op_q == OP_LW)
               mem_rd = 1'b1;
            else if (op_q == OP_SW)
               mem_wr_c = 1'b1;
         end
         S_WB: begin
            reg_wr_c   = 1'b1;
            reg_dst    = (op_q == OP_RTYPE);
            mem_to_reg = (op_q == OP_LW);
         end
         default: ;
      endcase
   end

   // Reset forces FETCH, whose mem_ready path would otherwise raise pc_wr/ir_wr during reset.
   assign pc_wr  = pc_wr_c & rst_n;
   assign ir_wr  = ir_wr_c & rst_n;
   assign mem_wr = mem_wr_c & rst_n;
   assign reg_wr = reg_wr_c & rst_n;

   assign state   = state_q;
   assign illegal = illegal_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Testbench for multicycle_ctrl: builds expected per-cycle traces from instruction-level rules
// (opcode, zero, memory wait counts) and checks every cycle; retire_cnt checked when enabled.
module tb_multicycle_ctrl;

   localparam int TO = 15;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_BNE  = 6'b000101;

   localparam logic [2:0] ST_FETCH  = 3'd0;
   localparam logic [2:0] ST_DECODE = 3'd1;
   localparam logic [2:0] ST_EXEC   = 3'd2;
   localparam logic [2:0] ST_MEM    = 3'd3;
   localparam logic [2:0] ST_WB     = 3'd4;
   localparam logic [2:0] ST_ERROR  = 3'd7;

   // Control bundle: {pc_wr,ir_wr,mem_rd,mem_wr,reg_wr,reg_dst,mem_to_reg,alu_src,pc_src,ext_op,alu_op}
   localparam logic [11:0] C_PCW    = 12'h800;
   localparam logic [11:0] C_IRW    = 12'h400;
   localparam logic [11:0] C_MRD    = 12'h200;
   localparam logic [11:0] C_MWR    = 12'h100;
   localparam logic [11:0] C_REGW   = 12'h080;
   localparam logic [11:0] C_REGDST = 12'h040;
   localparam logic [11:0] C_M2R    = 12'h020;
   localparam logic [11:0] C_ALUSRC = 12'h010;
   localparam logic [11:0] C_PCSRC  = 12'h008;
   localparam logic [11:0] C_EXT    = 12'h004;
   localparam logic [11:0] C_ALU_R  = 12'h002;
   localparam logic [11:0] C_ALU_BR = 12'h001;

   typedef struct packed {
      logic        rdy;
      logic        z;
      logic [5:0]  opc;
      logic [2:0]  st;
      logic [11:0] ctl;
      logic        ill;
      logic [15:0] rc;
   } step_t;

   logic        clk;
   logic        rst_n;
   logic [5:0]  opcode;
   logic        zero;
   logic        mem_ready;
   logic        pc_wr, ir_wr, mem_rd, mem_wr, reg_wr, reg_dst, mem_to_reg;
   logic        alu_src, pc_src, ext_op, illegal;
   logic [1:0]  alu_op;
   logic [2:0]  state;
`ifdef MULTICYCLE_CTRL_RETIRE_CNT_EN
   logic [15:0] retire_cnt;
`endif

   int          compared   = 0;
   int          mismatched = 0;
   int          step_idx   = 0;
   logic [15:0] model_retired = 16'd0;
   step_t       trace[$];
   logic [5:0]  legal_ops [6] = '{OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE};

   multicycle_ctrl #(.MEM_TIMEOUT(TO)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .opcode     (opcode),
      .zero       (zero),
      .mem_ready  (mem_ready),
      .pc_wr      (pc_wr),
      .ir_wr      (ir_wr),
      .mem_rd     (mem_rd),
      .mem_wr     (mem_wr),
      .reg_wr     (reg_wr),
      .reg_dst    (reg_dst),
      .mem_to_reg (mem_to_reg),
      .alu_src    (alu_src),
      .pc_src     (pc_src),
      .ext_op     (ext_op),
      .alu_op     (alu_op),
      .state      (state),
      .illegal    (illegal)
`ifdef MULTICYCLE_CTRL_RETIRE_CNT_EN
      ,
      .retire_cnt (retire_cnt)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic logic [5:0] ro();
      return 6'($urandom_range(0, 63));
   endfunction

   function automatic bit isLegal(input logic [5:0] op);
      foreach (legal_ops[i])
         if (legal_ops[i] == op) return 1'b1;
      return 1'b0;
   endfunction

   task automatic pushStep(input logic r, input logic z, input logic [5:0] opc,
                           input logic [2:0] st, input logic [11:0] ctl, input logic ill);
      step_t s;
      s.rdy = r; s.z = z; s.opc = opc; s.st = st; s.ctl = ctl; s.ill = ill;
      s.rc  = model_retired;
      trace.push_back(s);
   endtask

   task automatic pushError(input logic ill);
      for (int i = 0; i < 3; i++) pushStep(rb(), rb(), ro(), ST_ERROR, 12'h000, ill);
   endtask

   // One instruction as seen by the control: fetch waits, decode, then the opcode's path.
   task automatic buildInstr(input logic [5:0] op, input logic z, input int wf, input int wm,
                             output bit err);
      logic [11:0] acc;
      logic        taken;
      err = 1'b0;
      for (int i = 0; i < wf && i <= TO; i++) pushStep(1'b0, rb(), ro(), ST_FETCH, C_MRD, 1'b0);
      if (wf > TO) begin
         pushError(1'b0);
         err = 1'b1;
         return;
      end
      pushStep(1'b1, rb(), ro(), ST_FETCH, C_MRD | C_IRW | C_PCW, 1'b0);
      pushStep(rb(), rb(), op, ST_DECODE, 12'h000, 1'b0);
      if (!isLegal(op)) begin
         pushError(1'b1);
         err = 1'b1;
         return;
      end
      case (op)
         OP_R: begin
            pushStep(rb(), rb(), ro(), ST_EXEC, C_ALU_R, 1'b0);
            pushStep(rb(), rb(), ro(), ST_WB, C_REGW | C_REGDST, 1'b0);
         end
         OP_ADDI: begin
            pushStep(rb(), rb(), ro(), ST_EXEC, C_ALUSRC | C_EXT, 1'b0);
            pushStep(rb(), rb(), ro(), ST_WB, C_REGW, 1'b0);
         end
         OP_LW, OP_SW: begin
            acc = (op == OP_LW) ? C_MRD : C_MWR;
            pushStep(rb(), rb(), ro(), ST_EXEC, C_ALUSRC | C_EXT, 1'b0);
            for (int i = 0; i < wm && i <= TO; i++) pushStep(1'b0, rb(), ro(), ST_MEM, acc, 1'b0);
            if (wm > TO) begin
               pushError(1'b0);
               err = 1'b1;
               return;
            end
            pushStep(1'b1, rb(), ro(), ST_MEM, acc, 1'b0);
            if (op == OP_LW) pushStep(rb(), rb(), ro(), ST_WB, C_REGW | C_M2R, 1'b0);
         end
         default: begin
            taken = (op == OP_BEQ) ? z : !z;
            pushStep(rb(), z, ro(), ST_EXEC,
                     C_ALU_BR | C_EXT | C_PCSRC | (taken ? C_PCW : 12'h000), 1'b0);
         end
      endcase
      model_retired = model_retired + 16'd1;
   endtask

   task automatic applyStimulus(input step_t s);
      mem_ready = s.rdy;
      zero      = s.z;
      opcode    = s.opc;
   endtask

   task automatic checkOutput(input step_t s);
      logic [11:0] ctl_obs;
      ctl_obs = {pc_wr, ir_wr, mem_rd, mem_wr, reg_wr, reg_dst, mem_to_reg,
                 alu_src, pc_src, ext_op, alu_op};
      compared++;
      assert (state === s.st) else begin
         mismatched++;
         $error("[TB] FAIL state@%0d observed=%0d expected=%0d", step_idx, state, s.st);
      end
      compared++;
      assert (ctl_obs === s.ctl) else begin
         mismatched++;
         $error("[TB] FAIL ctl@%0d st=%0d observed=%03h expected=%03h", step_idx, s.st, ctl_obs, s.ctl);
      end
      compared++;
      assert (illegal === s.ill) else begin
         mismatched++;
         $error("[TB] FAIL illegal@%0d observed=%b expected=%b", step_idx, illegal, s.ill);
      end
`ifdef MULTICYCLE_CTRL_RETIRE_CNT_EN
      compared++;
      assert (retire_cnt === s.rc) else begin
         mismatched++;
         $error("[TB] FAIL retire_cnt@%0d observed=%0d expected=%0d", step_idx, retire_cnt, s.rc);
      end
`endif
      step_idx++;
   endtask

   task automatic playTrace(input int max_steps);
      step_t s;
      int    n;
      n = 0;
      while (trace.size() > 0 && n < max_steps) begin
         s = trace.pop_front();
         applyStimulus(s);
         @(negedge clk);
         checkOutput(s);
         @(posedge clk);
         #1;
         n++;
      end
   endtask

   task automatic checkReset(input string tag);
      compared++;
      assert (state === ST_FETCH && illegal === 1'b0) else begin
         mismatched++;
         $error("[TB] FAIL %s state/illegal observed=%0d/%b expected=0/0", tag, state, illegal);
      end
      compared++;
      assert ({pc_wr, reg_wr, mem_wr} === 3'b000) else begin
         mismatched++;
         $error("[TB] FAIL %s writes observed=%b expected=000", tag, {pc_wr, reg_wr, mem_wr});
      end
`ifdef MULTICYCLE_CTRL_RETIRE_CNT_EN
      compared++;
      assert (retire_cnt === 16'd0) else begin
         mismatched++;
         $error("[TB] FAIL %s retire_cnt observed=%0d expected=0", tag, retire_cnt);
      end
`endif
   endtask

   // Asserts reset mid-cycle with mem_ready high, holds it across an edge, releases it away from the edge.
   task automatic doReset();
      rst_n     = 1'b0;
      mem_ready = 1'b1;
      zero      = rb();
      opcode    = ro();
      #1;
      checkReset("rst_async");
      @(posedge clk);
      #1;
      checkReset("rst_held");
      trace.delete();
      model_retired = 16'd0;
      rst_n = 1'b1;
   endtask

   initial begin
      bit          err;
      logic [5:0]  op;
      int          wf, wm, pick, r;
      step_t       s;

      rst_n     = 1'b1;
      mem_ready = 1'b0;
      zero      = 1'b0;
      opcode    = 6'd0;
      #2;
      doReset();

      // R-type with memory always ready: FETCH, DECODE, EXEC, WB
      buildInstr(OP_R, 1'b0, 0, 0, err);
      playTrace(1000);

      // lw with three not-ready MEM cycles, then sw with two
      buildInstr(OP_LW, 1'b0, 1, 3, err);
      playTrace(1000);
      buildInstr(OP_SW, 1'b1, 0, 2, err);
      playTrace(1000);

      // Branches in both zero polarities
      buildInstr(OP_BEQ, 1'b1, 0, 0, err);
      buildInstr(OP_BEQ, 1'b0, 0, 0, err);
      buildInstr(OP_BNE, 1'b1, 0, 0, err);
      buildInstr(OP_BNE, 1'b0, 0, 0, err);
      buildInstr(OP_ADDI, 1'b0, 2, 0, err);
      playTrace(1000);

      // Ready arriving on the last permitted fetch cycle completes normally
      buildInstr(OP_ADDI, 1'b0, TO, 0, err);
      buildInstr(OP_LW, 1'b0, 0, TO, err);
      playTrace(1000);

      // Illegal opcode goes to ERROR with illegal set
      buildInstr(6'b111111, 1'b0, 0, 0, err);
      playTrace(1000);
      doReset();

      // Fetch timeout: ERROR with illegal clear
      buildInstr(OP_R, 1'b0, TO + 1, 0, err);
      playTrace(1000);
      doReset();

      // Reset asserted in the middle of EXEC aborts the instruction
      buildInstr(OP_R, 1'b0, 0, 0, err);
      buildInstr(OP_SW, 1'b0, 0, 0, err);
      playTrace(6);
      s = trace.pop_front();
      applyStimulus(s);
      #2;
      compared++;
      assert (state === ST_EXEC) else begin
         mismatched++;
         $error("[TB] FAIL pre_reset_exec observed=%0d expected=%0d", state, ST_EXEC);
      end
      doReset();

      // Randomized instruction stream with occasional boundary waits and illegal opcodes
      for (int n = 0; n < 300; n++) begin
         pick = $urandom_range(0, 15);
         if (pick < 14) op = legal_ops[$urandom_range(0, 5)];
         else op = ro();
         r  = $urandom_range(0, 31);
         wf = (r == 0) ? TO + 1 : (r == 1) ? TO : $urandom_range(0, 3);
         r  = $urandom_range(0, 31);
         wm = (r == 0) ? TO + 1 : (r == 1) ? TO : $urandom_range(0, 3);
         buildInstr(op, rb(), wf, wm, err);
         playTrace(1000);
         if (err) doReset();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
